// File: rtl/multicycle_control.sv
// Purpose : multi-cycle MIPS-subset sequencer (R-type, lw, sw, beq, addi, slti, andi, ori)
//           driving the shared memory/ALU/PC/IR/regfile datapath.
// Latency : beq 3, R-type/sw/I-type 4, lw 5 cycles with zero-wait memory; +1 per wait cycle.
// Backpr. : mem_ready handshake. Strobes are held while memory stalls. After MEM_TIMEOUT wait
//           cycles the instruction is aborted through ERROR back to FETCH.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   op               opcode from IR[31:26]; must stay stable for the whole instruction
//   mem_ready        memory completed the current read/write this cycle
//   pc_write(_cond)  PC load, unconditional / gated by ALU zero in the datapath
//   pc_source        00 ALU result, 01 ALUOut
//   i_or_d           memory address select: 0 PC, 1 ALUOut
//   mem_read/write   memory strobes, held until mem_ready
//   ir_write         IR load
//   reg_dst          1 rd, 0 rt
//   reg_write        register file write enable
//   mem_to_reg       1 MDR, 0 ALUOut
//   alu_src_a        0 PC, 1 A
//   alu_src_b        00 B, 01 4, 10 ext imm, 11 imm<<2
//   alu_op           00 add, 01 sub, 10 funct, 11 opcode (I-type)
//   state            current state (debug)
//   instr_done       pulse in the last cycle of each instruction
//   illegal_op       pulse when DECODE sees an unsupported opcode
//   mem_error        pulse when a memory access times out
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_error
);

  // State encoding is visible on the debug port, so the values are fixed.
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_I_EXEC    = 4'd9;
  localparam logic [3:0] S_I_WB      = 4'd10;
  localparam logic [3:0] S_ERROR     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // A zero timeout disables the abort path entirely; CNT_LAST is then unused.
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_TIMEOUT - 1);

  // All datapath controls travel together so that reset gating is one expression.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_error;
  } ctrl_t;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_legal;
  logic             in_wait_state;
  logic             timeout_hit;
  ctrl_t            ctrl;
  ctrl_t            ctrl_out;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  // The three states that wait on memory share one counter.
  always_comb begin
    in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                    (state_q == S_MEM_WRITE);
  end

  // mem_ready is tested first wherever this is used, so a completion in the
  // last allowed cycle still wins over the abort.
  always_comb begin
    timeout_hit = TIMEOUT_EN && !mem_ready && (cnt_q == CNT_LAST);
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_ERROR;
        else                  state_d = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_RTYPE:                         state_d = S_R_EXEC;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ:                           state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
          default:                          state_d = S_FETCH;
        endcase
      end
      // op is still the IR opcode here, so lw/sw can be split without an extra flop.
      S_MEM_ADDR: begin
        if (op == OP_LW)      state_d = S_MEM_READ;
        else if (op == OP_SW) state_d = S_MEM_WRITE;
        else                  state_d = S_FETCH;
      end
      S_MEM_READ: begin
        if (mem_ready)        state_d = S_MEM_WB;
        else if (timeout_hit) state_d = S_ERROR;
        else                  state_d = S_MEM_READ;
      end
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (timeout_hit) state_d = S_ERROR;
        else                  state_d = S_MEM_WRITE;
      end
      S_R_EXEC: state_d = S_R_WB;
      S_R_WB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_I_EXEC: state_d = S_I_WB;
      S_I_WB:   state_d = S_FETCH;
      S_ERROR:  state_d = S_FETCH;
      default:  state_d = S_FETCH; // unreachable codes 12-15 recover
    endcase
  end

  // Wait counter. The FSM only ever stays put in a wait state, so any state
  // change is an entry into a new access and restarts the count. Saturation
  // only matters when the timeout is disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_wait_state && !mem_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode (Moore, except the mem_ready-qualified strobes).
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        // IR and PC update only when the fetch data is actually there.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        ctrl.alu_src_b  = 2'b11;
        ctrl.illegal_op = !op_legal;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        ctrl.instr_done    = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = 2'b11;
      end
      S_I_WB: begin
        // slti writes rt as well; only the ALU op differs between I-types.
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ERROR: begin
        ctrl.mem_error = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Reset blanks every output immediately, before the state register settles.
  always_comb begin
    ctrl_out = rst ? '0 : ctrl;
  end

  assign state         = rst ? S_FETCH : state_q;
  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign pc_source     = ctrl_out.pc_source;
  assign i_or_d        = ctrl_out.i_or_d;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign ir_write      = ctrl_out.ir_write;
  assign reg_dst       = ctrl_out.reg_dst;
  assign reg_write     = ctrl_out.reg_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign instr_done    = ctrl_out.instr_done;
  assign illegal_op    = ctrl_out.illegal_op;
  assign mem_error     = ctrl_out.mem_error;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose : scoreboard bench for multicycle_control.
// Latency : one scoreboard entry per clock cycle.
// Backpr. : mem_ready is driven from the scoreboard entries.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_error;
  } ctrl_t;

  // One cycle of stimulus plus the state the DUT must show in that cycle.
  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       rst;
    logic [5:0] op;
  } ent_t;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, reg_write, mem_to_reg, alu_src_a;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;
  logic       instr_done, illegal_op, mem_error;

  ctrl_t      got;
  ent_t       sb[$];
  logic [5:0] cur_op;
  int         n_chk;
  int         n_err;
  int         done_seen, err_seen, ill_seen;
  int         cyc;

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_error(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    got = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, mem_error};
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference control word, written straight from the per-state output table.
  function automatic ctrl_t ref_ctrl(input logic [3:0] st, input logic rdy, input logic [5:0] o);
    ctrl_t c;
    c = '0;
    case (st)
      4'd0:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      4'd1:  begin
        c.alu_src_b  = 2'b11;
        c.illegal_op = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                   6'b001000, 6'b001010, 6'b001100, 6'b001101});
      end
      4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      4'd4:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
      4'd5:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = rdy; end
      4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
      4'd8:  begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.instr_done = 1'b1;
      end
      4'd9:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      4'd10: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      4'd11: begin c.mem_error = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic r, input logic [5:0] o);
    ent_t e;
    e.st = st; e.rdy = rdy; e.rst = r; e.op = o;
    sb.push_back(e);
  endtask

  // Normal cycle with the current instruction's opcode.
  task automatic pw(input logic [3:0] st, input logic rdy);
    push(st, rdy, 1'b0, cur_op);
  endtask

  // Drive each entry on the falling edge, compare 1 time unit later.
  task automatic drain(input string name);
    ent_t  e;
    ctrl_t exp_c;
    int    idx;
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst       = e.rst;
      mem_ready = e.rdy;
      op        = e.op;
      #1;
      exp_c = e.rst ? ctrl_t'('0) : ref_ctrl(e.st, e.rdy, e.op);
      chk($sformatf("%s c%0d state", name, idx), 32'(state), e.rst ? 32'd0 : 32'(e.st));
      chk($sformatf("%s c%0d ctrl", name, idx), 32'(got), 32'(exp_c));
      if (instr_done) done_seen++;
      if (mem_error)  err_seen++;
      if (illegal_op) ill_seen++;
      idx++;
      cyc++;
    end
  endtask

  task automatic run(input string name, input int exp_done, input int exp_err, input int exp_ill);
    done_seen = 0; err_seen = 0; ill_seen = 0;
    drain(name);
    chk({name, " done_cnt"}, 32'(done_seen), 32'(exp_done));
    chk({name, " err_cnt"},  32'(err_seen),  32'(exp_err));
    chk({name, " ill_cnt"},  32'(ill_seen),  32'(exp_ill));
  endtask

  initial begin
    logic [5:0] iops [3];
    n_chk = 0; n_err = 0; cyc = 0;
    rst = 1'b1; mem_ready = 1'b1; op = 6'b000000; cur_op = 6'b000000;

    // Reset held 3 cycles: everything reads 0.
    for (int i = 0; i < 3; i++) push(4'd0, 1'b1, 1'b1, 6'b000000);
    run("reset", 0, 0, 0);

    // R-type, zero-wait.
    cur_op = 6'b000000;
    pw(0, 1); pw(1, rnd()); pw(6, rnd()); pw(7, rnd());
    run("rtype", 1, 0, 0);

    // lw with two wait cycles in MEM_READ.
    cur_op = 6'b100011;
    pw(0, 1); pw(1, rnd()); pw(2, rnd());
    pw(3, 0); pw(3, 0); pw(3, 1); pw(4, rnd());
    run("lw_wait", 1, 0, 0);

    // sw that never completes: 15 cycles in MEM_WRITE, then ERROR.
    cur_op = 6'b101011;
    pw(0, 1); pw(1, rnd()); pw(2, rnd());
    for (int i = 0; i < 15; i++) pw(5, 0);
    pw(11, rnd());
    run("sw_timeout", 0, 1, 0);

    // lw whose memory answers in the very last allowed cycle.
    cur_op = 6'b100011;
    pw(0, 1); pw(1, rnd()); pw(2, rnd());
    for (int i = 0; i < 14; i++) pw(3, 0);
    pw(3, 1); pw(4, rnd());
    run("lw_edge", 1, 0, 0);

    // Fetch timeout, then a fresh fetch with its own wait budget.
    cur_op = 6'b000000;
    for (int i = 0; i < 15; i++) pw(0, 0);
    pw(11, rnd());
    run("fetch_timeout", 0, 1, 0);
    for (int i = 0; i < 3; i++) pw(0, 0);
    pw(0, 1); pw(1, rnd()); pw(6, rnd()); pw(7, rnd());
    run("rtype_after_err", 1, 0, 0);

    // Illegal opcode: back to FETCH after DECODE.
    cur_op = 6'b111111;
    pw(0, 1); pw(1, rnd());
    run("illegal", 0, 0, 1);

    // beq then slti.
    cur_op = 6'b000100;
    pw(0, 1); pw(1, rnd()); pw(8, rnd());
    run("beq", 1, 0, 0);
    cur_op = 6'b001010;
    pw(0, 1); pw(1, rnd()); pw(9, rnd()); pw(10, rnd());
    run("slti", 1, 0, 0);

    // sw with zero-wait memory.
    cur_op = 6'b101011;
    pw(0, 1); pw(1, rnd()); pw(2, rnd()); pw(5, 1);
    run("sw_fast", 1, 0, 0);

    // Remaining I-types.
    iops[0] = 6'b001000; iops[1] = 6'b001100; iops[2] = 6'b001101;
    for (int k = 0; k < 3; k++) begin
      cur_op = iops[k];
      pw(0, 1); pw(1, rnd()); pw(9, rnd()); pw(10, rnd());
      run($sformatf("itype%0d", k), 1, 0, 0);
    end

    // Reset during I_EXEC: next cycle is FETCH, never I_WB.
    cur_op = 6'b001000;
    pw(0, 1); pw(1, rnd());
    push(4'd0, 1'b1, 1'b1, cur_op);
    pw(0, 1); pw(1, rnd()); pw(9, rnd()); pw(10, rnd());
    run("rst_iexec", 1, 0, 0);

    // Reset in the middle of a MEM_READ wait.
    cur_op = 6'b100011;
    pw(0, 1); pw(1, rnd()); pw(2, rnd()); pw(3, 0); pw(3, 0);
    push(4'd0, 1'b0, 1'b1, cur_op);
    pw(0, 1); pw(1, rnd()); pw(2, rnd()); pw(3, 1); pw(4, rnd());
    run("rst_wait", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
